morph_filter: RTL

- 3x3 morphological erode/dilate stage on the luma stream; sits directly downstream of RGB2YUV, fed by its Y0 and delayed syncs.
- Default: binarises Y0 against a threshold and cleans noise before or in place of the edge stages. Output is RGB565 for VGA.
- Two line buffers plus a 3x3 window; syncs are delayed to match pixel latency.

---
 rtl/morph_filter_if.sv | 22 ++
 rtl/morph_filter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/morph_filter_if.sv
// Video port bundle for morph_filter: luma and syncs in, delayed syncs and RGB565 out.
interface morph_filter_if;
    logic        i_HSYNC;
    logic        i_VSYNC;
    logic        i_BLANK;
    logic [7:0]  i_Y0;
    logic        mode;
    logic        H_SYNC;
    logic        V_SYNC;
    logic        BLANK;
    logic [15:0] display_data;

    modport master (
        output i_HSYNC, i_VSYNC, i_BLANK, i_Y0, mode,
        input  H_SYNC, V_SYNC, BLANK, display_data
    );

    modport slave (
        input  i_HSYNC, i_VSYNC, i_BLANK, i_Y0, mode,
        output H_SYNC, V_SYNC, BLANK, display_data
    );
endinterface

// File: rtl/morph_filter.sv
// 3x3 erode/dilate on binarised luma; fixed 3-clock pipe with syncs matched.
// Define MORPH_GREY_EN for the 8-bit greyscale min/max variant.
module morph_filter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BIN_THRESH = 128
) (
    input logic           clk,
    input logic           rst_n,
    morph_filter_if.slave vid
);
`ifdef MORPH_GREY_EN
    localparam int PW = 8;
`else
    localparam int PW = 1;
`endif
    localparam int CW = $clog2(H_ACTIVE);
    localparam int RW = $clog2(V_ACTIVE);
    localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(V_ACTIVE - 1);

    typedef enum logic {WAIT_FRAME, RUN} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              hs_d, vs_d, bl_d;
    logic [CW-1:0]           col, s1_col, s2_col;
    logic [RW-1:0]           row, s1_row, s2_row;
    logic                    col_full, s1_valid, s2_valid, mode_q;
    logic                    blank_fall, vsync_fall, wr_en, show;
    logic [PW-1:0]           pix, cur_q, lb0_q, lb1_q;
    logic [PW-1:0]           lb0 [H_ACTIVE];
    logic [PW-1:0]           lb1 [H_ACTIVE];
    logic [2:0][2:0][PW-1:0] win;  // win[line][tap], line 0 = newest, tap 2 = newest column
    logic [PW-1:0]           red_min, red_max, result;
    logic [15:0]             packed_px, data_q;

    assign blank_fall = bl_d[0] & ~vid.i_BLANK;
    assign vsync_fall = vs_d[0] & ~vid.i_VSYNC;
    assign wr_en      = vid.i_BLANK & ~col_full;

`ifdef MORPH_GREY_EN
    assign pix       = vid.i_Y0;
    assign packed_px = {result[7:3], result[7:2], result[7:3]};
`else
    assign pix       = (vid.i_Y0 >= 8'(BIN_THRESH));
    assign packed_px = {16{result[0]}};
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d <= 3'b111;
            vs_d <= 3'b111;
            bl_d <= 3'b000;
        end else begin
            hs_d <= {hs_d[1:0], vid.i_HSYNC};
            vs_d <= {vs_d[1:0], vid.i_VSYNC};
            bl_d <= {bl_d[1:0], vid.i_BLANK};
        end
    end

    assign vid.H_SYNC       = hs_d[2];
    assign vid.V_SYNC       = vs_d[2];
    assign vid.BLANK        = bl_d[2];
    assign vid.display_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_FRAME;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_FRAME: if (!vid.i_VSYNC) state_nxt = RUN;
            default:    state_nxt = state;
        endcase
    end

    // NOTE: line buffers are not reset; rows 0-1 of every frame refill them before they can be shown.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb0[col] <= pix;
            lb1[col] <= lb0[col];
        end
        lb0_q <= lb0[col];
        lb1_q <= lb1[col];
    end

    // Counters, S1 side-band and S2 window shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            col_full <= 1'b0;
            row      <= '0;
            mode_q   <= 1'b0;
            cur_q    <= '0;
            s1_valid <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s2_valid <= 1'b0;
            s2_col   <= '0;
            s2_row   <= '0;
            win      <= '0;
        end else begin
            if (blank_fall) begin
                col      <= '0;
                col_full <= 1'b0;
            end else if (wr_en) begin
                if (col == COL_MAX) col_full <= 1'b1;
                else                col      <= col + 1'b1;
            end
            // VSYNC clear has priority over a coincident end-of-line increment.
            if (!vid.i_VSYNC)                      row <= '0;
            else if (blank_fall && row != ROW_MAX) row <= row + 1'b1;
            if (vsync_fall) mode_q <= vid.mode;

            cur_q    <= pix;
            s1_valid <= wr_en;
            s1_col   <= col;
            s1_row   <= row;

            win[0]   <= {cur_q, win[0][2:1]};
            win[1]   <= {lb0_q, win[1][2:1]};
            win[2]   <= {lb1_q, win[2][2:1]};
            s2_valid <= s1_valid;
            s2_col   <= s1_col;
            s2_row   <= s1_row;
        end
    end

    // On 1-bit taps min/max reduce to AND/OR, so one tree serves both builds.
    always_comb begin
        red_min = '1;
        red_max = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (win[r][c] < red_min) red_min = win[r][c];
                if (win[r][c] > red_max) red_max = win[r][c];
            end
        end
        result = mode_q ? red_max : red_min;
    end

    assign show = s2_valid && (s2_row >= RW'(2)) && (s2_col >= CW'(2)) && (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= 16'h0000;
        else        data_q <= show ? packed_px : 16'h0000;
    end
endmodule
